// File: rtl/imm_pkg.sv
// Shared decode constants for the immediate generator: RV32 opcodes,
// shift funct3 codes and the output format enumeration.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32 immediate decode: inst -> sign-extended imm, format, illegal.
// Zero latency; no state, no flow control.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [31:0] imm32;
  logic        use_shamt;

  always_comb begin
    imm32     = '0;
    use_shamt = 1'b0;
    fmt_o     = FMT_R;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OPC_LOAD, OPC_JALR: begin
        fmt_o = FMT_I;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_OP_IMM: begin
        fmt_o     = FMT_I;
        use_shamt = (inst_i[14:12] == F3_SLLI) || (inst_i[14:12] == F3_SRXI);
        imm32     = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm32 = {inst_i[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OPC_OP: fmt_o = FMT_R;
      default: illegal_o = 1'b1;
    endcase

    // Shift immediates carry an unsigned shamt whose width follows XLEN.
    if (use_shamt)
      imm_o = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
    else
      imm_o = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode then STAGES bubble-collapsing register stages.
// Latency STAGES cycles; valid/ready backpressure, in_ready depends combinationally on out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  logic [STAGES-1:0] vld_w;
  logic [STAGES-1:0] rdy;
  logic [XLEN-1:0]   imm_w [STAGES];
  fmt_e              fmt_w [STAGES];
  logic              ill_w [STAGES];
  logic              down_rdy;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  // A stage can take new data when it is empty or its content moves on.
  always_comb begin
    rdy      = '0;
    down_rdy = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy[s]   = !vld_w[s] || down_rdy;
      down_rdy = rdy[s];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic            vld_q, vld_d, up_vld;
    logic [XLEN-1:0] imm_q, imm_d, up_imm;
    fmt_e            fmt_q, fmt_d, up_fmt;
    logic            ill_q, ill_d, up_ill;

    if (s == 0) begin : g_src
      assign up_vld = in_valid;
      assign up_imm = dec_imm;
      assign up_fmt = dec_fmt;
      assign up_ill = dec_ill;
    end else begin : g_src
      assign up_vld = vld_w[s-1];
      assign up_imm = imm_w[s-1];
      assign up_fmt = fmt_w[s-1];
      assign up_ill = ill_w[s-1];
    end

    always_comb begin
      vld_d = vld_q;
      imm_d = imm_q;
      fmt_d = fmt_q;
      ill_d = ill_q;
      if (flush) begin
        vld_d = 1'b0;
      end else if (rdy[s]) begin
        vld_d = up_vld;
        if (up_vld) begin
          imm_d = up_imm;
          fmt_d = up_fmt;
          ill_d = up_ill;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        imm_q <= '0;
        fmt_q <= FMT_R;
        ill_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
        imm_q <= imm_d;
        fmt_q <= fmt_d;
        ill_q <= ill_d;
      end
    end

    assign vld_w[s] = vld_q;
    assign imm_w[s] = imm_q;
    assign fmt_w[s] = fmt_q;
    assign ill_w[s] = ill_q;
  end

  assign in_ready  = rdy[0] || flush;
  assign out_valid = vld_w[STAGES-1];
  assign imm       = imm_w[STAGES-1];
  assign fmt       = fmt_w[STAGES-1];
  assign illegal   = ill_w[STAGES-1];

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64 only.
REQ-002 SHALL have parameter STAGES, default 1, number of pipeline register stages; legal 1..4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous pipeline clear.
REQ-006 SHALL have port in_valid  input  1  instruction offered.
REQ-007 SHALL have port in_ready  output  1  block accepts instruction this cycle.
REQ-008 SHALL have port inst  input  32  RV32 instruction word.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port imm  output  XLEN  sign-extended immediate.
REQ-012 SHALL have port fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-013 SHALL have port illegal  output  1  opcode not recognised.

Function
REQ-014 SHALL decode by inst[6:0]: 0000011, 0010011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> R.
REQ-015 SHALL form I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U = sext({inst[31:12],12'b0}); J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); sign bit is inst[31], extended to XLEN.
REQ-016 SHALL, for opcode 0010011 with funct3 001 or 101, output shamt zero-extended: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
REQ-017 SHALL output imm=0, fmt=R, illegal=0 for R-type.
REQ-018 SHALL output imm=0, fmt=R, illegal=1 for any other opcode; no X on any output.
REQ-019 SHALL accept a transfer when in_valid && in_ready; SHALL deliver when out_valid && out_ready.
REQ-020 SHALL have latency exactly STAGES cycles from accept to out_valid with an unstalled pipe.
REQ-021 SHALL sustain one instruction per cycle with out_ready held high.
REQ-022 SHALL let each stage advance when the next stage is empty or advancing (bubble-collapsing); in_ready = stage 1 empty or stage 1 advancing.
REQ-023 SHALL hold imm/fmt/illegal stable while out_valid && !out_ready.
REQ-024 SHALL preserve order; no drop or duplicate under any out_ready pattern.
REQ-025 SHALL combinationally depend in_ready on out_ready only; no combinational path from inst to any output.
REQ-026 SHALL, on flush, clear all stage valid bits next edge; an instruction offered in the flush cycle is discarded; in_ready=1 during flush.
REQ-027 SHALL treat flush and rst asserted together as reset.

Reset
REQ-028 SHALL, while rst=1, force all valid bits 0 immediately (async): out_valid=0, in_ready=1.
REQ-029 SHALL reset all stage data registers to 0: imm=0, fmt=R, illegal=0.
REQ-030 SHALL, when rst rises mid-stream, lose all in-flight instructions; first accept possible on the first edge after rst falls.

Structure
REQ-031 SHALL place opcode constants, fmt enum type and shamt funct3 values in shared package imm_pkg.
REQ-032 SHALL isolate decode in a combinational sub-module imm_decode (inst -> imm, fmt, illegal), instanced before stage 1; stages built by generate loop.

Verification
REQ-033 SHALL cover formats, XLEN=32: 0xFFF00093 -> imm 0xFFFFFFFF, fmt I; 0xFE20AE23 -> 0xFFFFFFFC, fmt S; 0x123452B7 -> 0x12345000, fmt U; 0xFFDFF06F -> 0xFFFFFFFC, fmt J; 0x00D00113 (imm 13) -> 0x0000000D, fmt I.
REQ-034 SHALL cover illegal: 0x0000007F -> imm 0, fmt R, illegal 1; 0x00B50533 -> imm 0, fmt R, illegal 0.
REQ-035 SHALL cover XLEN=64: 0x800002B7 -> 0xFFFFFFFF80000000; slli 0x03F51513 -> imm 63.
REQ-036 SHALL cover backpressure, STAGES=2: 4 back-to-back inputs, out_ready low 3 cycles -> in_ready low after 2 accepts, all 4 delivered in order, outputs stable while stalled.
REQ-037 SHALL cover flush, STAGES=3: full pipe, flush 1 cycle -> out_valid 0 next cycle, flush-cycle input never appears.
REQ-038 SHALL cover async reset mid-stream: rst between edges, pipe full -> out_valid 0 before next edge, imm 0.
